// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared 640x480@60 VGA timing constants and helpers, used by the timing
// generator, the renderer and the top level.
//   - *_DEF constants : default porch/sync/active sizes for 640x480@60
//   - CNT_W           : width of the horizontal/vertical counters
//   - RGB_W           : width of the packed {r,g,b} pin bus
//   - calc_total()    : sums the four segments of one raster axis
// ----------------------------------------------------------------------------
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;

    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned RGB_W = 6;

    function automatic int unsigned calc_total(
        input int unsigned active,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// ----------------------------------------------------------------------------
// vga_sync_delay
// Fixed-depth (0..3) shift register for the 3-bit {active, hs, vs} flag group.
// Depth 0 is a combinational pass-through.
// Ports:
//   clk     : system clock, shifts every cycle
//   rst_n   : asynchronous active-low clear, stages load CLEAR_VAL
//   i_data  : flags entering the line
//   o_data  : flags delayed by DEPTH cycles
// ----------------------------------------------------------------------------
module vga_sync_delay #(
    parameter int unsigned DEPTH     = 1,
    parameter logic [2:0]  CLEAR_VAL = 3'b000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_data,
    output logic [2:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Clock and reset are not needed in pass-through mode.
            logic w_unused_clk_rst;
            assign w_unused_clk_rst = clk ^ rst_n;
            assign o_data = i_data;
        end else begin : g_shift
            logic [2:0] r_stage [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= CLEAR_VAL;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
// Raster timing source: pixel-tick divider, h/v counters, sync/blank decode,
// a delay line matching the renderer's pixel latency, and registered pins.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   enable        : run enable; low holds counters at 0 and blanks the decode
//   pixel_in      : renderer pixel, valid PIX_LATENCY clk after the counters
//   horizCounter  : current column 0..H_TOTAL-1
//   vertCounter   : current line 0..V_TOTAL-1
//   display_on    : delayed active-area flag
//   hsync, vsync  : delayed sync pins, asserted level SYNC_POL
//   rgb           : {r,g,b}, FG_RGB for a lit active pixel, else 0
//   frame_start   : one-clk pulse after the tick that wraps to (0,0)
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned       H_ACTIVE    = H_ACTIVE_DEF,
    parameter int unsigned       H_FP        = H_FP_DEF,
    parameter int unsigned       H_SYNC      = H_SYNC_DEF,
    parameter int unsigned       H_BP        = H_BP_DEF,
    parameter int unsigned       V_ACTIVE    = V_ACTIVE_DEF,
    parameter int unsigned       V_FP        = V_FP_DEF,
    parameter int unsigned       V_SYNC      = V_SYNC_DEF,
    parameter int unsigned       V_BP        = V_BP_DEF,
    parameter bit                SYNC_POL    = 1'b0,
    parameter int unsigned       CLK_DIV     = 1,
    parameter int unsigned       PIX_LATENCY = 1,
    parameter logic [RGB_W-1:0]  FG_RGB      = 6'b111111
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             pixel_in,
    output logic [CNT_W-1:0] horizCounter,
    output logic [CNT_W-1:0] vertCounter,
    output logic             display_on,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start
);

    localparam int unsigned H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_END = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT_END = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [1:0]       DIV_LAST  = 2'(CLK_DIV - 1);

    logic [1:0]       r_div;
    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_frame_start;
    logic             r_display_on;
    logic             r_hsync;
    logic             r_vsync;
    logic [RGB_W-1:0] r_rgb;

    logic             w_tick;
    logic             w_active;
    logic             w_hs;
    logic             w_vs;
    logic [2:0]       w_dly;

    assign w_tick = (r_div == DIV_LAST);

    // Dropping enable wins over a coincident tick: everything returns to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
        end else if (!enable) begin
            r_div         <= '0;
            r_h           <= '0;
            r_v           <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (w_tick) begin
                r_div <= '0;
                if (r_h == H_LAST) begin
                    r_h <= '0;
                    if (r_v == V_LAST) begin
                        r_v           <= '0;
                        r_frame_start <= 1'b1;
                    end else begin
                        r_v <= r_v + 1'b1;
                    end
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end else begin
                r_div <= r_div + 2'd1;
            end
        end
    end

    // Raw decode; forced blank with sync deasserted while disabled.
    assign w_active = enable && (r_h < H_ACT_END) && (r_v < V_ACT_END);
    assign w_hs     = enable && (r_h >= HS_FIRST) && (r_h <= HS_LAST);
    assign w_vs     = enable && (r_v >= VS_FIRST) && (r_v <= VS_LAST);

    vga_sync_delay #(
        .DEPTH     (PIX_LATENCY),
        .CLEAR_VAL (3'b000)
    ) u_sync_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_data ({w_active, w_hs, w_vs}),
        .o_data (w_dly)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display_on <= 1'b0;
            r_hsync      <= ~SYNC_POL;
            r_vsync      <= ~SYNC_POL;
            r_rgb        <= '0;
        end else begin
            r_display_on <= w_dly[2];
            r_hsync      <= w_dly[1] ? SYNC_POL : ~SYNC_POL;
            r_vsync      <= w_dly[0] ? SYNC_POL : ~SYNC_POL;
            r_rgb        <= (w_dly[2] && pixel_in) ? FG_RGB : '0;
        end
    end

    assign horizCounter = r_h;
    assign vertCounter  = r_v;
    assign display_on   = r_display_on;
    assign hsync        = r_hsync;
    assign vsync        = r_vsync;
    assign rgb          = r_rgb;
    assign frame_start  = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ----------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generator instances (two shrunk rasters, one full 640x480) driven by a
// shared clock, reset and enable, with random pixel data. A position model
// derived from the count of enabled clocks predicts counters, frame pulses and
// the delayed pin values.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int NI = 3;
    localparam int unsigned HA  [NI] = '{16, 16, 640};
    localparam int unsigned HF  [NI] = '{2, 3, 16};
    localparam int unsigned HSY [NI] = '{4, 5, 96};
    localparam int unsigned HB  [NI] = '{3, 2, 48};
    localparam int unsigned VA  [NI] = '{8, 6, 480};
    localparam int unsigned VF  [NI] = '{1, 2, 10};
    localparam int unsigned VSY [NI] = '{2, 1, 2};
    localparam int unsigned VB  [NI] = '{2, 3, 33};
    localparam bit          POL [NI] = '{1'b0, 1'b1, 1'b0};
    localparam int unsigned CD  [NI] = '{1, 4, 2};
    localparam int unsigned LAT [NI] = '{1, 3, 0};
    localparam logic [5:0]  FG  [NI] = '{6'b111111, 6'b101010, 6'b010101};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pix   [NI];
    logic [9:0] h_o   [NI];
    logic [9:0] v_o   [NI];
    logic       don_o [NI];
    logic       hs_o  [NI];
    logic       vs_o  [NI];
    logic [5:0] rgb_o [NI];
    logic       fs_o  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        vga_timing_gen #(
            .H_ACTIVE    (HA[gi]),
            .H_FP        (HF[gi]),
            .H_SYNC      (HSY[gi]),
            .H_BP        (HB[gi]),
            .V_ACTIVE    (VA[gi]),
            .V_FP        (VF[gi]),
            .V_SYNC      (VSY[gi]),
            .V_BP        (VB[gi]),
            .SYNC_POL    (POL[gi]),
            .CLK_DIV     (CD[gi]),
            .PIX_LATENCY (LAT[gi]),
            .FG_RGB      (FG[gi])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .enable       (enable),
            .pixel_in     (pix[gi]),
            .horizCounter (h_o[gi]),
            .vertCounter  (v_o[gi]),
            .display_on   (don_o[gi]),
            .hsync        (hs_o[gi]),
            .vsync        (vs_o[gi]),
            .rgb          (rgb_o[gi]),
            .frame_start  (fs_o[gi])
        );
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 8;
    int          pix_mode = 0;
    int unsigned n_en     [NI];   // enabled clocks since last reset/disable
    logic        exp_fs   [NI];
    logic [2:0]  raw_hist [NI][8];
    logic        pix_hist [NI][8];
    int          last_fs  [NI];
    bit          fs_clean [NI];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int unsigned htot(input int i);
        return HA[i] + HF[i] + HSY[i] + HB[i];
    endfunction

    function automatic int unsigned vtot(input int i);
        return VA[i] + VF[i] + VSY[i] + VB[i];
    endfunction

    // Raster position reached after nn enabled clocks.
    function automatic int unsigned pos_of(input int i, input int unsigned nn);
        return (nn / CD[i]) % (htot(i) * vtot(i));
    endfunction

    function automatic logic [2:0] flags_at(input int i, input int unsigned p);
        int unsigned h, v;
        h = p % htot(i);
        v = p / htot(i);
        return {h < HA[i] && v < VA[i],
                h >= HA[i] + HF[i] && h < HA[i] + HF[i] + HSY[i],
                v >= VA[i] + VF[i] && v < VA[i] + VF[i] + VSY[i]};
    endfunction

    task automatic check_reset_pins(input int i, input string when);
        check_eq($sformatf("%s_h[%0d]", when, i), 32'(h_o[i]), 0);
        check_eq($sformatf("%s_v[%0d]", when, i), 32'(v_o[i]), 0);
        check_eq($sformatf("%s_don[%0d]", when, i), 32'(don_o[i]), 0);
        check_eq($sformatf("%s_hs[%0d]", when, i), 32'(hs_o[i]), 32'(!POL[i]));
        check_eq($sformatf("%s_vs[%0d]", when, i), 32'(vs_o[i]), 32'(!POL[i]));
        check_eq($sformatf("%s_rgb[%0d]", when, i), 32'(rgb_o[i]), 0);
        check_eq($sformatf("%s_fs[%0d]", when, i), 32'(fs_o[i]), 0);
    endtask

    // Called just after a falling edge: drive pixels, advance the model over
    // the next rising edge, then check everything at the following falling edge.
    task automatic run_cycle();
        for (int i = 0; i < NI; i++) begin
            int unsigned t0, t1;
            case (pix_mode)
                0:       pix[i] = 1'($urandom);
                1:       pix[i] = 1'b1;
                default: pix[i] = h_o[i][0];
            endcase
            raw_hist[i][cyc % 8] = (rst_n && enable) ? flags_at(i, pos_of(i, n_en[i])) : 3'b000;
            pix_hist[i][cyc % 8] = pix[i];
            t0 = n_en[i] / CD[i];
            if (!rst_n || !enable) n_en[i] = 0;
            else                   n_en[i]++;
            t1 = n_en[i] / CD[i];
            exp_fs[i] = rst_n && enable && (t1 != t0) && (t1 % (htot(i) * vtot(i)) == 0);
        end
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                check_reset_pins(i, "rst");
                fs_clean[i] = 1'b0;
            end else begin
                logic [2:0] r;
                logic       p;
                int unsigned pos;
                pos = pos_of(i, n_en[i]);
                r   = raw_hist[i][(cyc - int'(LAT[i]) - 1) % 8];
                p   = pix_hist[i][(cyc - 1) % 8];
                check_eq($sformatf("h[%0d]", i), 32'(h_o[i]), pos % htot(i));
                check_eq($sformatf("v[%0d]", i), 32'(v_o[i]), pos / htot(i));
                check_eq($sformatf("fs[%0d]", i), 32'(fs_o[i]), 32'(exp_fs[i]));
                check_eq($sformatf("don[%0d]", i), 32'(don_o[i]), 32'(r[2]));
                check_eq($sformatf("hs[%0d]", i), 32'(hs_o[i]), 32'(r[1] ? POL[i] : !POL[i]));
                check_eq($sformatf("vs[%0d]", i), 32'(vs_o[i]), 32'(r[0] ? POL[i] : !POL[i]));
                check_eq($sformatf("rgb[%0d]", i), 32'(rgb_o[i]),
                         (r[2] && p) ? 32'(FG[i]) : 32'd0);
                if (!enable) fs_clean[i] = 1'b0;
                if (fs_o[i] === 1'b1) begin
                    if (fs_clean[i]) begin
                        check_eq($sformatf("fs_period[%0d]", i), 32'(cyc - last_fs[i]),
                                 htot(i) * vtot(i) * CD[i]);
                    end
                    last_fs[i]  = cyc;
                    fs_clean[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) run_cycle();
    endtask

    // Bounded wait until instance 0 reaches (h, v); a miss counts as a failure.
    task automatic wait_pos0(input int unsigned h, input int unsigned v, input string tag);
        int k;
        k = 0;
        while (!(h_o[0] == 10'(h) && v_o[0] == 10'(v)) && k < 3000) begin
            run_cycle();
            k++;
        end
        check_eq(tag, 32'(h_o[0] == 10'(h) && v_o[0] == 10'(v)), 1);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < NI; i++) begin
            pix[i]      = 1'b0;
            n_en[i]     = 0;
            exp_fs[i]   = 1'b0;
            last_fs[i]  = 0;
            fs_clean[i] = 1'b0;
            for (int j = 0; j < 8; j++) begin
                raw_hist[i][j] = 3'b000;
                pix_hist[i][j] = 1'b0;
            end
        end
        @(negedge clk);
        run_n(5);

        // Free-running with random pixels: several frames of the small rasters.
        rst_n  = 1'b1;
        enable = 1'b1;
        run_n(3000);

        // Pixel held high: rgb must still be 0 outside the active area.
        pix_mode = 1;
        run_n(700);

        // Enable dropped mid-frame for 50 clk, then resumed.
        pix_mode = 0;
        wait_pos0(10, 3, "reach_h10_v3");
        enable = 1'b0;
        run_n(50);
        enable = 1'b1;
        run_n(400);

        // Random short enable drops.
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
            run_cycle();
        end
        enable = 1'b1;
        run_n(100);

        // Asynchronous reset asserted mid-line inside the hsync region.
        wait_pos0(20, 2, "reach_h20");
        #2;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_reset_pins(i, "async");
            n_en[i] = 0;
        end
        run_n(6);
        rst_n = 1'b1;

        // Pixel follows counter parity after the restart.
        pix_mode = 2;
        run_n(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing source for the 640x480@60 VGA output path. Generates the `horizCounter`/`vertCounter` pair that `clockRenderer` consumes, takes back its registered `pixel_bw`, and drives sync and 2-bit RGB pins. Sync and blanking are delayed so they line up with the renderer's pixel latency.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)
- `CLK_DIV`, 1, clk cycles per pixel tick (1..4)
- `PIX_LATENCY`, 1, clk cycles from counter value to matching `pixel_in` (0..3)
- `FG_RGB`, 6'b111111, {r,g,b} colour driven for a lit pixel

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  timing run enable
- `pixel_in`  in  1  pixel from renderer, valid `PIX_LATENCY` clk after counters
- `horizCounter`  out  10  current column, 0..H_TOTAL-1
- `vertCounter`  out  10  current line, 0..V_TOTAL-1
- `display_on`  out  1  delayed active-area flag
- `hsync`  out  1  delayed horizontal sync
- `vsync`  out  1  delayed vertical sync
- `rgb`  out  6  {r[1:0],g[1:0],b[1:0]}, registered
- `frame_start`  out  1  one-clk pulse on frame wrap

## Operation
- H_TOTAL = sum of the H params (800); V_TOTAL = sum of the V params (525). Both are derived locally.
- Pixel tick: a divider counts 0..CLK_DIV-1. The tick fires when the divider is at CLK_DIV-1. With CLK_DIV=1, every clk is a tick.
- On a tick:
  - h increments. At H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 at V_TOTAL-1 on the same tick that h wraps.
- Counters are registers, driven directly onto `horizCounter`/`vertCounter`.
- Raw decode from the counters:
  - active = h<H_ACTIVE && v<V_ACTIVE
  - hs = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 656..751
  - vs = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 490..491
- Delay line: {active, hs, vs} shift through `PIX_LATENCY` clk stages, clocked every clk regardless of tick. `PIX_LATENCY`=0 means a pass-through.
- Output register, every clk:
  - `display_on` <= delayed active
  - `hsync` <= (delayed hs ? SYNC_POL : ~SYNC_POL); `vsync` likewise from delayed vs
  - `rgb` <= (delayed active && `pixel_in`) ? FG_RGB : 0
- `frame_start`: one clk high on the clk after the tick that moves (H_TOTAL-1, V_TOTAL-1) to (0,0).
- `enable` low:
  - divider, h and v are held at 0; the raw decode is forced to blank with sync deasserted.
  - When `enable` rises, the first tick moves h to 1. No `frame_start` is produced by resuming.
- Arithmetic is unsigned, 10-bit. Comparisons use localparam constants, not runtime adds.

## Timing
- Reset (async, `rst_n` low):
  - h=0, v=0, divider=0, delay stages cleared to blank with sync deasserted
  - `display_on`=0, `hsync`=`vsync`=~SYNC_POL, `rgb`=0, `frame_start`=0
- After reset is released, the first tick is at clk edge CLK_DIV.
- Counter to pin latency: sync, `display_on` and `rgb` reflect counter value N exactly PIX_LATENCY+1 clk after N appears on the counters.
- `pixel_in` is sampled combinationally into the `rgb` register. There is no handshake.
- Simultaneous events:
  - h wrap, v wrap and `frame_start` arise from one tick.
  - `enable` falling on a tick cycle wins: counters go to 0, not increment.
- Reset mid-frame: counters restart at (0,0) and the delay line is flushed. There is no partial-line output.

## Structure
- Package `vga_pkg`: 640x480@60 timing constants, H_TOTAL/V_TOTAL derivation function, RGB width localparam. Shared with the renderer and top level.
- Sub-module `vga_sync_delay`: parameterised-depth (0..3), 3-bit-wide shift register with async active-low clear to the deasserted pattern.
- Top level: divider, h/v counters, decode, output register.

## Test plan
- Reset then run 2 frames, CLK_DIV=1, PIX_LATENCY=1 -> h wraps 799->0, v wraps 524->0, exactly 420000 clk between `frame_start` pulses.
- Sync and blanking widths -> `hsync` low for 96 ticks beginning at h=656 (seen 2 clk later); `vsync` low for 2 lines at v=490..491; `display_on` high 640 ticks per visible line, 480 lines.
- `pixel_in` tied to counter parity, delayed 1 clk -> `rgb`=6'b111111 on odd columns and 0 on even, only while `display_on`; 0 during blanking even when `pixel_in`=1.
- CLK_DIV=2 -> counters advance every 2nd clk; `frame_start` period 840000 clk.
- `enable` dropped at h=300,v=100 for 50 clk, then raised -> counters 0 while low, outputs blank with sync high; resumes 1,2,…; no `frame_start` on resume.
- `rst_n` asserted mid-line at h=700 -> all outputs at reset values immediately (async); after release the counters restart from 0.
